// File: rtl/stream_pack_acc.sv
// Lane accumulator for stream_pack_src: writes narrow words into ascending lanes,
// tracks keep/last, and raises close on a full lane set, a last word, or idle timeout.
module stream_pack_acc #(
    parameter int DATA_W  = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    last_i,
    input  logic                    accept_i,
    input  logic                    fill_i,
    input  logic                    clear_i,
    output logic                    close_o,
    output logic [RATIO*DATA_W-1:0] beat_data_o,
    output logic [RATIO-1:0]        beat_keep_o,
    output logic                    beat_last_o
);

    localparam int CNT_W = $clog2(RATIO);
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(RATIO - 1);
    localparam logic [TO_W-1:0]  IDLE_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0]  IDLE_MAX  = '1;

    logic [RATIO*DATA_W-1:0] data_q;
    logic [RATIO-1:0]        keep_q;
    logic                    last_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [TO_W-1:0]         idle_q;
    logic                    idle_close;

    // The beat view already contains the word accepted on this edge, so a
    // closing word can go straight to the output register without a bubble.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        beat_data_o = data_q;
        beat_keep_o = keep_q;
        beat_last_o = last_q | (accept_i & last_i);
        for (int k = 0; k < RATIO; k++) begin
            if (accept_i && (cnt_q == CNT_W'(k))) begin
                beat_data_o[k*DATA_W +: DATA_W] = data_i;
                beat_keep_o[k]                  = 1'b1;
            end
        end
        idle_close = (TIMEOUT > 0) && fill_i && !accept_i &&
                     (cnt_q != '0) && (idle_q == IDLE_LAST);
        close_o    = (accept_i && ((cnt_q == LANE_LAST) || last_i)) || idle_close;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else if (accept_i) begin
            data_q <= beat_data_o;
            keep_q <= beat_keep_o;
            last_q <= beat_last_o;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Idle counter only runs while a partial beat is waiting in FILL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q <= '0;
        end else if (clear_i || accept_i || close_o || (cnt_q == '0)) begin
            idle_q <= '0;
        end else if (fill_i && (idle_q != IDLE_MAX)) begin
            idle_q <= idle_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/stream_pack_src.sv
// Width-up packer feeding the two-phase CDC source side: RATIO narrow words per
// wide beat, with an output register and a FILL/HELD accumulator control.
module stream_pack_src #(
    parameter int DATA_W  = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic                    in_valid_i,
    input  logic                    in_last_i,
    output logic                    in_ready_o,
    output logic [RATIO*DATA_W-1:0] out_data_o,
    output logic [RATIO-1:0]        out_keep_o,
    output logic                    out_last_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    typedef enum logic {
        FILL = 1'b0,
        HELD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    accept;
    logic                    close;
    logic                    obuf_free;
    logic                    transfer;
    logic [RATIO*DATA_W-1:0] beat_data;
    logic [RATIO-1:0]        beat_keep;
    logic                    beat_last;

    // Ready depends on registered state only, never on out_ready_i.
    assign in_ready_o = (state_q == FILL);
    assign accept     = in_valid_i && in_ready_o;
    assign obuf_free  = !out_valid_o || out_ready_i;

    stream_pack_acc #(
        .DATA_W  (DATA_W),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) u_acc (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (in_data_i),
        .last_i      (in_last_i),
        .accept_i    (accept),
        .fill_i      (state_q == FILL),
        .clear_i     (transfer),
        .close_o     (close),
        .beat_data_o (beat_data),
        .beat_keep_o (beat_keep),
        .beat_last_o (beat_last)
    );

    always_comb begin
        state_d  = state_q;
        transfer = 1'b0;
        unique case (state_q)
            FILL: begin
                if (close) begin
                    if (obuf_free) transfer = 1'b1;
                    else           state_d  = HELD;
                end
            end
            HELD: begin
                // obuf is necessarily valid here, so ready means it drains now.
                if (out_ready_i) begin
                    transfer = 1'b1;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= FILL;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_o  <= '0;
            out_keep_o  <= '0;
            out_last_o  <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (transfer) begin
            out_data_o  <= beat_data;
            out_keep_o  <= beat_keep;
            out_last_o  <= beat_last;
            out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
            out_data_o  <= '0;
            out_keep_o  <= '0;
            out_last_o  <= 1'b0;
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_pack_src.sv
// Self-checking bench for stream_pack_src: directed scenarios plus randomized traffic
// scored against a queue-based model of closed beats.
module tb_stream_pack_src;

    localparam int DATA_W  = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 8;
    localparam int BW      = RATIO * DATA_W;

    typedef struct {
        logic [BW-1:0]    data;
        logic [RATIO-1:0] keep;
        logic             last;
    } beat_t;

    logic              clk_i;
    logic              rst_ni;
    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_last_i;
    logic              in_ready_o;
    logic [BW-1:0]     out_data_o;
    logic [RATIO-1:0]  out_keep_o;
    logic              out_last_o;
    logic              out_valid_o;
    logic              out_ready_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: beats closed but not yet delivered (obuf first, then a held beat),
    // plus the words of the beat still being collected.
    beat_t             exp_q[$];
    logic [DATA_W-1:0] cur_q[$];
    int                idle_cnt = 0;

    stream_pack_src #(
        .DATA_W  (DATA_W),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_keep_o  (out_keep_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_close(input logic last);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = last;
        for (int k = 0; k < cur_q.size(); k++) begin
            b.data[k*DATA_W +: DATA_W] = cur_q[k];
            b.keep[k]                  = 1'b1;
        end
        exp_q.push_back(b);
        cur_q.delete();
        idle_cnt = 0;
    endtask

    task automatic compare_outputs();
        check("out_valid", 64'(out_valid_o), 64'(exp_q.size() > 0));
        check("in_ready", 64'(in_ready_o), 64'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            check("out_data", 64'(out_data_o), 64'(exp_q[0].data));
            check("out_keep", 64'(out_keep_o), 64'(exp_q[0].keep));
            check("out_last", 64'(out_last_o), 64'(exp_q[0].last));
        end else begin
            check("idle_data", 64'(out_data_o), 64'(0));
            check("idle_keep", 64'(out_keep_o), 64'(0));
            check("idle_last", 64'(out_last_o), 64'(0));
        end
    endtask

    // One clock: compare at the negedge, drive, then advance the model across the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic r);
        bit pre_ready;
        bit pre_valid;
        compare_outputs();
        pre_ready  = (exp_q.size() < 2);
        pre_valid  = (exp_q.size() > 0);
        in_valid_i = v;
        in_data_i  = d;
        in_last_i  = l;
        out_ready_i = r;
        @(posedge clk_i);
        cyc++;
        if (pre_valid && r) void'(exp_q.pop_front());
        if (v && pre_ready) begin
            cur_q.push_back(d);
            idle_cnt = 0;
            if (cur_q.size() == RATIO || l) model_close(l);
        end else if (cur_q.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) model_close(1'b0);
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        rst_ni     = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid_o), 64'(0));
        check("rst_data", 64'(out_data_o), 64'(0));
        check("rst_keep", 64'(out_keep_o), 64'(0));
        check("rst_last", 64'(out_last_o), 64'(0));
        exp_q.delete();
        cur_q.delete();
        idle_cnt = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("rst_ready", 64'(in_ready_o), 64'(1));
    endtask

    initial begin
        int t0;
        int t_valid;
        rst_ni      = 1'b0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        do_reset();

        // Full beat back-to-back, then eight words without an in_ready drop.
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(8'h11 * (i + 1)), 1'b0, 1'b1);
        check("t1_valid", 64'(out_valid_o), 64'(1));
        check("t1_data", 64'(out_data_o), 64'(32'h44332211));
        check("t1_keep", 64'(out_keep_o), 64'(4'b1111));
        check("t1_last", 64'(out_last_o), 64'(0));
        for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(i + 1), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Early close on last, next word restarts at lane 0.
        step(1'b1, 8'hA1, 1'b0, 1'b1);
        step(1'b1, 8'hA2, 1'b1, 1'b1);
        check("t2_data", 64'(out_data_o), 64'(32'h0000A2A1));
        check("t2_keep", 64'(out_keep_o), 64'(4'b0011));
        check("t2_last", 64'(out_last_o), 64'(1));
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        check("t2_restart", 64'(out_data_o), 64'(32'h0000005A));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Timeout flush of a single word: valid in the 9th cycle after the accept cycle.
        t0 = cyc;
        step(1'b1, 8'h05, 1'b0, 1'b1);
        t_valid = -1;
        for (int i = 0; i < 30 && t_valid < 0; i++) begin
            if (out_valid_o) t_valid = cyc;
            else             step(1'b0, '0, 1'b0, 1'b0);
        end
        check("t3_latency", 64'(t_valid - t0), 64'(TIMEOUT + 1));
        check("t3_data", 64'(out_data_o), 64'(32'h00000005));
        check("t3_keep", 64'(out_keep_o), 64'(4'b0001));
        check("t3_last", 64'(out_last_o), 64'(0));
        for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Stalled output: obuf fills, accumulator holds, ready drops.
        for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(8'h11 * (i + 1)), 1'b0, 1'b0);
        check("t4_ready", 64'(in_ready_o), 64'(0));
        check("t4_obuf", 64'(out_data_o), 64'(32'h44332211));
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("t4_stable", 64'(out_data_o), 64'(32'h44332211));
        step(1'b0, '0, 1'b0, 1'b1);
        check("t4_second", 64'(out_data_o), 64'(32'h88776655));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Reset with a partial beat, then with a stalled full obuf.
        step(1'b1, 8'h31, 1'b0, 1'b1);
        step(1'b1, 8'h32, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40, 1'b0, 1'b0);
        check("t5_stalled", 64'(out_valid_o), 64'(1));
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(i + 1), 1'b0, 1'b1);
        check("t5_data", 64'(out_data_o), 64'(32'h04030201));
        check("t5_keep", 64'(out_keep_o), 64'(4'b1111));
        step(1'b0, '0, 1'b0, 1'b1);

        // Accept on the edge the timeout would expire: no early close.
        step(1'b1, 8'hC1, 1'b0, 1'b1);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'hC2, 1'b0, 1'b1);
        check("t6_no_close", 64'(out_valid_o), 64'(0));
        step(1'b1, 8'hC3, 1'b0, 1'b1);
        step(1'b1, 8'hC4, 1'b1, 1'b1);
        check("t6_data", 64'(out_data_o), 64'(32'hC4C3C2C1));
        check("t6_keep", 64'(out_keep_o), 64'(4'b1111));
        check("t6_last", 64'(out_last_o), 64'(1));
        step(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic in phases: dense, mixed, sparse (timeouts), heavy stall.
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 100; i++) begin
                logic v;
                logic r;
                logic l;
                case (blk % 4)
                    0:       begin v = 1'b1;                      r = 1'b1; end
                    1:       begin v = ($urandom % 2) == 0;       r = ($urandom % 10) < 7; end
                    2:       begin v = ($urandom % 12) == 0;      r = ($urandom % 4) != 0; end
                    default: begin v = ($urandom % 4) != 0;       r = ($urandom % 5) == 0; end
                endcase
                l = ($urandom % 6) == 0;
                step(v, DATA_W'($urandom), l, r);
            end
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1);
        compare_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
